// File: rtl/cmult_share_sched_if.sv
// Bundle between the multiplier-sharing scheduler and its surroundings:
// the two requesters, the shared multiplier and the tagged result stream.
interface cmult_share_sched_if #(
    parameter int WIDTH = 8
);
    logic                    enable;
    logic                    req0_valid, req0_ready;
    logic signed [WIDTH-1:0] req0_ar, req0_ai, req0_br, req0_bi;
    logic                    req1_valid, req1_ready;
    logic signed [WIDTH-1:0] req1_ar, req1_ai, req1_br, req1_bi;
    logic                    m_enable;
    logic [1:0]              m_ind;
    logic signed [WIDTH-1:0] m_ar, m_ai, m_br, m_bi;
    logic signed [WIDTH-1:0] m_zr, m_zi;
    logic                    out_valid, out_chan;
    logic signed [WIDTH-1:0] out_zr, out_zi;
    logic                    busy;

    modport slave (
        input  enable,
        input  req0_valid, req0_ar, req0_ai, req0_br, req0_bi,
        output req0_ready,
        input  req1_valid, req1_ar, req1_ai, req1_br, req1_bi,
        output req1_ready,
        output m_enable, m_ind, m_ar, m_ai, m_br, m_bi,
        input  m_zr, m_zi,
        output out_valid, out_chan, out_zr, out_zi, busy
    );

    modport master (
        output enable,
        output req0_valid, req0_ar, req0_ai, req0_br, req0_bi,
        input  req0_ready,
        output req1_valid, req1_ar, req1_ai, req1_br, req1_bi,
        input  req1_ready,
        input  m_enable, m_ind, m_ar, m_ai, m_br, m_bi,
        output m_zr, m_zi,
        input  out_valid, out_chan, out_zr, out_zi, busy
    );
endinterface

// File: rtl/cmult_share_sched.sv
// Round-robin sharer for one time-multiplexed complex multiplier: holds operands
// for a full phase sweep and returns each result tagged with its requester.
module cmult_share_sched #(
    parameter int WIDTH  = 8,
    parameter int PHASES = 4,
    parameter int LAT    = 2
) (
    input logic                clk,
    input logic                reset,
    cmult_share_sched_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

    state_t                  state, state_nxt;
    logic [1:0]              phase, phase_nxt;
    logic                    enable, slot, accept, gsel, last_cycle;
    logic                    last_grant;
    logic signed [WIDTH-1:0] m_ar_p0, m_ai_p0, m_br_p0, m_bi_p0;
    logic [LAT-1:0]          tag_vld_p1, tag_chan_p1;
    logic                    out_vld_p2, out_chan_p2;
    logic signed [WIDTH-1:0] out_zr_p2, out_zi_p2;

    assign enable = bus.enable;

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        last_cycle = (state == RUN) && (phase == LAST_PHASE);
        slot       = enable && ((state == IDLE) || last_cycle);
        accept     = slot && (bus.req0_valid || bus.req1_valid);
        // Contention goes to whoever did not win last; a lone requester always wins.
        gsel       = bus.req1_valid && (!bus.req0_valid || !last_grant);
        if (enable) begin
            if (accept) begin
                state_nxt = RUN;
                phase_nxt = 2'd0;
            end else if (state == RUN) begin
                if (last_cycle) begin
                    state_nxt = IDLE;
                    phase_nxt = 2'd0;
                end else begin
                    phase_nxt = phase + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            phase <= 2'd0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant  <= 1'b1;
            m_ar_p0     <= '0;
            m_ai_p0     <= '0;
            m_br_p0     <= '0;
            m_bi_p0     <= '0;
            tag_vld_p1  <= '0;
            tag_chan_p1 <= '0;
            out_vld_p2  <= 1'b0;
            out_chan_p2 <= 1'b0;
            out_zr_p2   <= '0;
            out_zi_p2   <= '0;
        end else if (enable) begin
            // p0: operand capture, held for the whole phase sweep
            if (accept) begin
                last_grant <= gsel;
                m_ar_p0    <= gsel ? bus.req1_ar : bus.req0_ar;
                m_ai_p0    <= gsel ? bus.req1_ai : bus.req0_ai;
                m_br_p0    <= gsel ? bus.req1_br : bus.req0_br;
                m_bi_p0    <= gsel ? bus.req1_bi : bus.req0_bi;
            end
            // p1: tag follows the multiplier latency; last_grant still names the running op
            tag_vld_p1[0]  <= last_cycle;
            tag_chan_p1[0] <= last_grant;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_p1[i]  <= tag_vld_p1[i-1];
                tag_chan_p1[i] <= tag_chan_p1[i-1];
            end
            // p2: result capture when the tag leaves the pipe
            out_vld_p2 <= tag_vld_p1[LAT-1];
            if (tag_vld_p1[LAT-1]) begin
                out_chan_p2 <= tag_chan_p1[LAT-1];
                out_zr_p2   <= bus.m_zr;
                out_zi_p2   <= bus.m_zi;
            end
        end
    end

    assign bus.req0_ready = slot && bus.req0_valid && !gsel;
    assign bus.req1_ready = slot && gsel;
    assign bus.m_enable   = enable;
    assign bus.m_ind      = (state == RUN) ? {phase[1] & (PHASES == 4), phase[0]} : 2'b00;
    assign bus.m_ar       = m_ar_p0;
    assign bus.m_ai       = m_ai_p0;
    assign bus.m_br       = m_br_p0;
    assign bus.m_bi       = m_bi_p0;
    // A strobe caught by a disabled cycle stays pending and shows once enable returns.
    assign bus.out_valid  = out_vld_p2 && enable;
    assign bus.out_chan   = out_chan_p2;
    assign bus.out_zr     = out_zr_p2;
    assign bus.out_zi     = out_zi_p2;
    assign bus.busy       = (state == RUN) || (|tag_vld_p1) || out_vld_p2;
endmodule

// File: tb/tb_cmult_share_sched.sv
// Bench for cmult_share_sched: directed vectors with hand-computed products feed a
// scoreboard; a monitor pops and compares on every result strobe.
module tb_cmult_share_sched;
    typedef struct packed {
        logic [7:0] ar, ai, br, bi, zr, zi;
    } vec_t;
    typedef struct packed {
        logic       chan;
        logic [7:0] zr, zi;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cmult_share_sched_if #(.WIDTH(8)) bus_a ();
    cmult_share_sched_if #(.WIDTH(8)) bus_b ();

    cmult_share_sched #(.WIDTH(8), .PHASES(4), .LAT(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    cmult_share_sched #(.WIDTH(8), .PHASES(2), .LAT(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Behavioural shared multiplier: LAT-deep product pipe that freezes with m_enable.
    function automatic logic [15:0] cmul(input logic signed [7:0] ar, ai, br, bi);
        logic signed [15:0] zr, zi;
        zr = ar * br - ai * bi;
        zi = ar * bi + ai * br;
        return {zr[7:0], zi[7:0]};
    endfunction

    logic [15:0] mul_a [2];
    logic [15:0] mul_b;
    always @(posedge clk) begin
        if (bus_a.m_enable) begin
            mul_a[0] <= cmul(bus_a.m_ar, bus_a.m_ai, bus_a.m_br, bus_a.m_bi);
            mul_a[1] <= mul_a[0];
        end
    end
    always @(posedge clk) begin
        if (bus_b.m_enable) mul_b <= cmul(bus_b.m_ar, bus_b.m_ai, bus_b.m_br, bus_b.m_bi);
    end
    assign bus_a.m_zr = $signed(mul_a[1][15:8]);
    assign bus_a.m_zi = $signed(mul_a[1][7:0]);
    assign bus_b.m_zr = $signed(mul_b[15:8]);
    assign bus_b.m_zi = $signed(mul_b[7:0]);

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vec_t tab0 [10];
    vec_t tab1 [6];
    exp_t exp_a [$];
    exp_t exp_b [$];
    int   acc_cyc_a [$];
    logic acc_chan_a [$];
    int   stb_a [$];
    int   acc_cyc_b [$];
    int   stb_b [$];
    int   pa0 = 0, la0 = 0, pa1 = 0, la1 = 0, pb1 = 0, lb1 = 0;
    logic en_a = 1'b1;
    logic b_ind_hi = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int ar, ai, br, bi, input logic [7:0] zr, zi);
        vec_t v;
        v.ar = ar[7:0]; v.ai = ai[7:0]; v.br = br[7:0]; v.bi = bi[7:0];
        v.zr = zr;      v.zi = zi;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic drive();
        vec_t v;
        bus_a.enable     = en_a;
        bus_b.enable     = 1'b1;
        bus_a.req0_valid = (pa0 < la0);
        v = tab0[(pa0 < 10) ? pa0 : 0];
        {bus_a.req0_ar, bus_a.req0_ai, bus_a.req0_br, bus_a.req0_bi} = {v.ar, v.ai, v.br, v.bi};
        bus_a.req1_valid = (pa1 < la1);
        v = tab1[(pa1 < 6) ? pa1 : 0];
        {bus_a.req1_ar, bus_a.req1_ai, bus_a.req1_br, bus_a.req1_bi} = {v.ar, v.ai, v.br, v.bi};
        bus_b.req0_valid = 1'b0;
        {bus_b.req0_ar, bus_b.req0_ai, bus_b.req0_br, bus_b.req0_bi} = '0;
        bus_b.req1_valid = (pb1 < lb1);
        v = tab1[(pb1 < 6) ? pb1 : 0];
        {bus_b.req1_ar, bus_b.req1_ai, bus_b.req1_br, bus_b.req1_bi} = {v.ar, v.ai, v.br, v.bi};
    endtask

    // One clock: new inputs after the rising edge, handshakes recorded mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        #1;
        if (bus_a.req0_valid && bus_a.req0_ready) begin
            exp_a.push_back({1'b0, tab0[pa0].zr, tab0[pa0].zi});
            acc_cyc_a.push_back(cyc); acc_chan_a.push_back(1'b0); pa0++;
        end
        if (bus_a.req1_valid && bus_a.req1_ready) begin
            exp_a.push_back({1'b1, tab1[pa1].zr, tab1[pa1].zi});
            acc_cyc_a.push_back(cyc); acc_chan_a.push_back(1'b1); pa1++;
        end
        if (bus_b.req1_valid && bus_b.req1_ready) begin
            exp_b.push_back({1'b1, tab1[pb1].zr, tab1[pb1].zi});
            acc_cyc_b.push_back(cyc); pb1++;
        end
    endtask

    task automatic wait_idle_a(input string nm);
        int n = 0;
        while (!(pa0 == la0 && pa1 == la1 && exp_a.size() == 0 && !bus_a.busy) && n < 200) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, (n < 200) ? 1 : 0, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.m_ind[1]) b_ind_hi <= 1'b1;
        if (bus_a.out_valid) begin
            stb_a.push_back(cyc);
            n_tests++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL sb_a: unexpected strobe chan=%0d zr=%h zi=%h", bus_a.out_chan, bus_a.out_zr, bus_a.out_zi);
            end else begin
                e = exp_a.pop_front();
                if ({bus_a.out_chan, bus_a.out_zr, bus_a.out_zi} !== e) begin
                    n_fail++;
                    $display("FAIL sb_a: got chan=%0d zr=%h zi=%h, expected chan=%0d zr=%h zi=%h",
                             bus_a.out_chan, bus_a.out_zr, bus_a.out_zi, e.chan, e.zr, e.zi);
                end
            end
        end
        if (bus_b.out_valid) begin
            stb_b.push_back(cyc);
            n_tests++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL sb_b: unexpected strobe chan=%0d zr=%h zi=%h", bus_b.out_chan, bus_b.out_zr, bus_b.out_zi);
            end else begin
                e = exp_b.pop_front();
                if ({bus_b.out_chan, bus_b.out_zr, bus_b.out_zi} !== e) begin
                    n_fail++;
                    $display("FAIL sb_b: got chan=%0d zr=%h zi=%h, expected chan=%0d zr=%h zi=%h",
                             bus_b.out_chan, bus_b.out_zr, bus_b.out_zi, e.chan, e.zr, e.zi);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int na, ns, cnt, nb;
        tab0[0] = mk(   3,  2,    1,  4, 8'hFB, 8'h0E);
        tab0[1] = mk(-128,  0, -128,  0, 8'h00, 8'h00);
        tab0[2] = mk(-128,  1,   -1,  0, 8'h80, 8'hFF);
        tab0[3] = mk(   2,  1,    3, -1, 8'h07, 8'h01);
        tab0[4] = mk(  -4,  5,    2,  3, 8'hE9, 8'hFE);
        tab0[5] = mk(  10, 10,   10,-10, 8'hC8, 8'h00);
        tab0[6] = mk(   1,  0,    1,  0, 8'h01, 8'h00);
        tab0[7] = mk(   2,  2,    2, -2, 8'h08, 8'h00);
        tab0[8] = mk(  -3,  1,    4,  2, 8'hF2, 8'hFE);
        tab0[9] = mk(   0,  1,    0,  1, 8'hFF, 8'h00);
        tab1[0] = mk(   1,  1,    1,  1, 8'h00, 8'h02);
        tab1[1] = mk(   5,  0,    0,  3, 8'h00, 8'h0F);
        tab1[2] = mk(  -1, -1,    2,  0, 8'hFE, 8'hFE);
        tab1[3] = mk(   7,  3,   -2,  4, 8'hE6, 8'h16);
        tab1[4] = mk(   0, -3,    0, -3, 8'hF7, 8'h00);
        tab1[5] = mk(   6,  1,    6,  1, 8'h23, 8'h0C);

        reset = 1'b1;
        drive();
        #3 reset = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", bus_a.out_valid, 0);
        chk("rst_busy",      bus_a.busy, 0);
        chk("rst_m_ind",     bus_a.m_ind, 0);
        chk("rst_m_ar",      bus_a.m_ar, 0);
        chk("rst_out_zr",    bus_a.out_zr, 0);
        chk("rst_out_chan",  bus_a.out_chan, 0);
        reset = 1'b1;
        repeat (2) tick();

        // Single operation: phase sweep, steady operands, latency and busy.
        na = acc_cyc_a.size(); ns = stb_a.size();
        la0 = pa0 + 1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i <= 4) begin
                chk("t1_m_ind", bus_a.m_ind, i - 1);
                chk("t1_m_ar", bus_a.m_ar, 3);
            end
            if (i == 7) chk("t1_busy_c7", bus_a.busy, 1);
            if (i == 8) chk("t1_busy_c8", bus_a.busy, 0);
        end
        wait_idle_a("t1");
        chk("t1_latency", stb_a[ns] - acc_cyc_a[na], 7);

        // Sign/width corners, back to back.
        la0 = pa0 + 2;
        wait_idle_a("t6");

        // Enable low for three cycles at phase 2 of the second op, first strobe pending.
        na = acc_cyc_a.size(); ns = stb_a.size();
        la0 = pa0 + 2;
        tick();
        repeat (6) tick();
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_frozen_m_ind", bus_a.m_ind, 2);
            chk("t4_frozen_valid", bus_a.out_valid, 0);
        end
        chk("t4_frozen_m_ar", bus_a.m_ar, -4);
        en_a = 1'b1;
        wait_idle_a("t4");
        chk("t4_spacing", acc_cyc_a[na + 1] - acc_cyc_a[na], 4);
        chk("t4_delay_op1", stb_a[ns] - acc_cyc_a[na], 10);
        chk("t4_delay_op2", stb_a[ns + 1] - acc_cyc_a[na + 1], 10);

        // Reset at phase 1 of the second op with the first result in flight.
        la0 = pa0 + 2;
        tick();
        repeat (6) tick();
        reset = 1'b0;
        bus_a.req0_valid = 1'b0;
        la0 = pa0;
        exp_a.delete();
        #1;
        chk("t5_m_ar",      bus_a.m_ar, 0);
        chk("t5_m_ind",     bus_a.m_ind, 0);
        chk("t5_out_zr",    bus_a.out_zr, 0);
        chk("t5_busy",      bus_a.busy, 0);
        chk("t5_out_valid", bus_a.out_valid, 0);
        repeat (2) tick();
        reset = 1'b1;
        ns = stb_a.size();
        repeat (12) tick();
        chk("t5_no_strobe", stb_a.size() - ns, 0);

        // Contention after reset: requester 0 first, then strict alternation every 4 cycles.
        na = acc_cyc_a.size();
        la0 = pa0 + 3;
        la1 = pa1 + 3;
        wait_idle_a("t2");
        chk("t2_accepts", acc_cyc_a.size() - na, 6);
        if (acc_cyc_a.size() - na == 6) begin
            for (int k = 0; k < 6; k++) begin
                chk("t2_grant", acc_chan_a[na + k], k % 2);
                if (k > 0) chk("t2_spacing", acc_cyc_a[na + k] - acc_cyc_a[na + k - 1], 4);
            end
        end

        // Two-phase instance, requester 1 only, five back-to-back ops.
        cnt = 0; nb = 0;
        lb1 = 5;
        while (!(pb1 == lb1 && exp_b.size() == 0 && !bus_b.busy) && nb < 100) begin
            tick();
            nb++;
            if (bus_b.m_ind == 2'd1) cnt++;
        end
        chk("t3_timeout", (nb < 100) ? 1 : 0, 1);
        chk("t3_ind1_cycles", cnt, 5);
        chk("t3_ind_bit1", b_ind_hi, 0);
        chk("t3_accepts", acc_cyc_b.size(), 5);
        chk("t3_strobes", stb_b.size(), 5);
        if (acc_cyc_b.size() == 5 && stb_b.size() == 5) begin
            chk("t3_latency", stb_b[0] - acc_cyc_b[0], 4);
            for (int k = 1; k < 5; k++) begin
                chk("t3_acc_spacing", acc_cyc_b[k] - acc_cyc_b[k - 1], 2);
                chk("t3_stb_spacing", stb_b[k] - stb_b[k - 1], 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
